// File: rtl/row_port_arbiter.sv
// Round-robin arbiter sharing the host row-read port between the snapshot loader (0)
// and the lookahead reader (1). Rows beyond the board are answered locally as a full floor.
module row_port_arbiter_lane (
  input  logic       clk,
  input  logic       reset,
  input  logic       grant,
  input  logic       finish,
  input  logic       clear,
  input  logic [9:0] fin_data,
  output logic       gnt,
  output logic       done,
  output logic [9:0] data
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt  <= 1'b0;
      done <= 1'b0;
      data <= '0;
    end else begin
      if (grant) gnt <= 1'b1;
      if (finish) begin
        done <= 1'b1;
        data <= fin_data;
      end
      if (clear) begin
        gnt  <= 1'b0;
        done <= 1'b0;
      end
    end
  end
endmodule

module row_port_arbiter #(
  parameter int HOST_LAT = 1,
  parameter int NUM_ROWS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       host_ready,
  output logic       row_req,
  output logic [5:0] row,
  input  logic [9:0] row_info,
  input  logic       req0,
  input  logic       req1,
  input  logic [5:0] row0,
  input  logic [5:0] row1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [9:0] data0,
  output logic [9:0] data1,
  output logic       busy
);
  localparam int         NREQ     = 2;
  localparam logic [5:0] NR       = 6'(NUM_ROWS);
  localparam logic [1:0] CNT_INIT = 2'(HOST_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nx;

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0][5:0]  rows;
  logic                  last, cur, sel, grant_en, in_range;
  logic [1:0]            cnt;
  logic [NREQ-1:0]       lane_grant, lane_finish;
  logic                  lane_clear;
  logic [9:0]            fin_data;
  logic [NREQ-1:0]       gnt_v, done_v;
  logic [NREQ-1:0][9:0]  data_v;

  assign req  = {req1, req0};
  assign rows = {row1, row0};

  always_comb begin
    sel         = (req[0] & req[1]) ? ~last : req[1];
    in_range    = rows[sel] < NR;
    grant_en    = (state == IDLE) && host_ready && (|req);
    state_nx    = state;
    lane_grant  = '0;
    lane_finish = '0;
    lane_clear  = 1'b0;
    fin_data    = row_info;
    case (state)
      IDLE: if (grant_en) begin
        lane_grant[sel] = 1'b1;
        if (in_range) state_nx = ISSUE;
        else begin
          lane_finish[sel] = 1'b1;
          fin_data         = 10'h3FF;
          state_nx         = DONE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: if (cnt == 2'd0) begin
        lane_finish[cur] = 1'b1;
        state_nx         = DONE;
      end
      // Requests are deliberately ignored here so a requester dropping req on done is not re-granted.
      DONE: begin
        lane_clear = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // last resets to 1 so a simultaneous request pair favours requester 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_req <= 1'b0;
      row     <= '0;
      last    <= 1'b1;
      cur     <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else begin
      busy    <= (state_nx != IDLE);
      row_req <= grant_en & in_range;
      if (grant_en) begin
        last <= sel;
        cur  <= sel;
        if (in_range) row <= rows[sel];
      end
      if (state == ISSUE)     cnt <= CNT_INIT;
      else if (state == WAIT) cnt <= cnt - 2'd1;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    row_port_arbiter_lane u_lane (
      .clk      (clk),
      .reset    (reset),
      .grant    (lane_grant[i]),
      .finish   (lane_finish[i]),
      .clear    (lane_clear),
      .fin_data (fin_data),
      .gnt      (gnt_v[i]),
      .done     (done_v[i]),
      .data     (data_v[i])
    );
  end

  assign gnt0  = gnt_v[0];
  assign gnt1  = gnt_v[1];
  assign done0 = done_v[0];
  assign done1 = done_v[1];
  assign data0 = data_v[0];
  assign data1 = data_v[1];
endmodule

// File: tb/tb_row_port_arbiter.sv
// Scoreboard bench for row_port_arbiter: HOST_LAT=1 instance for the main scenarios,
// HOST_LAT=4 instance for the long-latency sampling point.
module tb_row_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // HOST_LAT = 1 instance
  logic       host_ready, row_req, req0, req1, gnt0, gnt1, done0, done1, busy;
  logic [5:0] row, row0, row1;
  logic [9:0] row_info, data0, data1;

  // HOST_LAT = 4 instance
  logic       host_ready_b, row_req_b, req0_b, req1_b, gnt0_b, gnt1_b, done0_b, done1_b, busy_b;
  logic [5:0] row_b, row0_b, row1_b;
  logic [9:0] row_info_b, data0_b, data1_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0]  exp_row_q[$];
  logic [10:0] exp_done_q[$];
  logic [10:0] exp_done_b_q[$];

  function automatic logic [9:0] host_val(input logic [5:0] r);
    case (r)
      6'd5:    host_val = 10'b1100000011;
      6'd3:    host_val = 10'h0F3;
      6'd7:    host_val = 10'h2A5;
      default: host_val = 10'h111;
    endcase
  endfunction

  assign row_info = host_val(row);

  row_port_arbiter #(.HOST_LAT(1), .NUM_ROWS(20)) dut (
    .clk(clk), .reset(reset), .host_ready(host_ready), .row_req(row_req), .row(row),
    .row_info(row_info), .req0(req0), .req1(req1), .row0(row0), .row1(row1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .data0(data0), .data1(data1), .busy(busy));

  row_port_arbiter #(.HOST_LAT(4), .NUM_ROWS(20)) dut_b (
    .clk(clk), .reset(reset), .host_ready(host_ready_b), .row_req(row_req_b), .row(row_b),
    .row_info(row_info_b), .req0(req0_b), .req1(req1_b), .row0(row0_b), .row1(row1_b),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .done0(done0_b), .done1(done1_b),
    .data0(data0_b), .data1(data1_b), .busy(busy_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever a DUT presents row_req or a done pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (row_req) begin
        if (exp_row_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_row_req: row %0d with nothing expected", row);
        end else check("row_req_row", 32'(row), 32'(exp_row_q.pop_front()));
      end
      if (done0 | done1) begin
        if (exp_done_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: done0=%0b done1=%0b with nothing expected", done0, done1);
        end else check("done_id_data", {21'd0, done1, done1 ? data1 : data0},
                       {21'd0, exp_done_q.pop_front()});
        if (done0 & done1) check("done_onehot", 32'd1, 32'd0);
      end
      if (done0_b | done1_b) begin
        if (exp_done_b_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done_lat4: done0=%0b done1=%0b", done0_b, done1_b);
        end else check("lat4_done_id_data", {21'd0, done1_b, done1_b ? data1_b : data0_b},
                       {21'd0, exp_done_b_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; host_ready = 1'b1; req0 = 0; req1 = 0; row0 = 0; row1 = 0;
    host_ready_b = 1'b1; req0_b = 0; req1_b = 0; row0_b = 0; row1_b = 0; row_info_b = '0;
    repeat (2) @(negedge clk);
    check("rst_row_req", 32'(row_req), 0);
    check("rst_row", 32'(row), 0);
    check("rst_gnt", 32'({gnt0, gnt1}), 0);
    check("rst_done", 32'({done0, done1}), 0);
    check("rst_data", 32'({data0, data1}), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;

    // HOST_LAT=4: data taken from row_info exactly at edge E+5
    @(negedge clk);
    req0_b = 1'b1; row0_b = 6'd19;
    exp_done_b_q.push_back({1'b0, 10'h305});
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      row_info_b = 10'h300 + 10'(k);
      if (k == 1) check("lat4_row", 32'(row_b), 19);
      if (k == 5) check("lat4_not_early", 32'(done0_b), 0);
    end
    @(negedge clk);
    check("lat4_done_at_E5", 32'(done0_b), 1);
    req0_b = 1'b0; row_info_b = 10'h3AA;
    @(negedge clk);
    check("lat4_data_held", 32'(data0_b), 32'h305);

    // single read, HOST_LAT=1
    @(negedge clk);
    req0 = 1'b1; row0 = 6'd5;
    exp_row_q.push_back(6'd5);
    exp_done_q.push_back({1'b0, 10'b1100000011});
    @(negedge clk);
    check("single_gnt0", 32'(gnt0), 1);
    @(negedge clk);
    check("single_no_early_done", 32'(done0), 0);
    check("single_row_req_low", 32'(row_req), 0);
    @(negedge clk);
    check("single_done0", 32'(done0), 1);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    check("single_idle_busy", 32'(busy), 0);
    check("single_idle_gnt", 32'({gnt0, gnt1}), 0);

    // contention from reset: 0,1,0,1 every 4 edges
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; row0 = 6'd3; row1 = 6'd7;
    for (int i = 0; i < 2; i++) begin
      exp_row_q.push_back(6'd3);
      exp_row_q.push_back(6'd7);
      exp_done_q.push_back({1'b0, 10'h0F3});
      exp_done_q.push_back({1'b1, 10'h2A5});
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k % 4 == 0) begin
        check("rr_gnt0", 32'(gnt0), (k % 8 == 0) ? 1 : 0);
        check("rr_gnt1", 32'(gnt1), (k % 8 == 4) ? 1 : 0);
        check("rr_row_req", 32'(row_req), 1);
      end
      if (k == 15) begin req0 = 1'b0; req1 = 1'b0; end
    end

    // out of range: answered locally, no host access, row unchanged
    @(negedge clk);
    req1 = 1'b1; row1 = 6'd20;
    exp_done_q.push_back({1'b1, 10'h3FF});
    @(negedge clk);
    check("oor20_done1", 32'(done1), 1);
    check("oor20_no_row_req", 32'(row_req), 0);
    check("oor20_row_kept", 32'(row), 7);
    req1 = 1'b0;
    @(negedge clk);
    req1 = 1'b1; row1 = 6'd63;
    exp_done_q.push_back({1'b1, 10'h3FF});
    @(negedge clk);
    check("oor63_done1", 32'(done1), 1);
    check("oor63_row_kept", 32'(row), 7);
    req1 = 1'b0;
    @(negedge clk);

    // host_ready gating
    host_ready = 1'b0; req0 = 1'b1; row0 = 6'd9;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hr_gate_no_grant", 32'({row_req, busy}), 0);
    end
    host_ready = 1'b1;
    exp_row_q.push_back(6'd9);
    exp_done_q.push_back({1'b0, 10'h111});
    @(negedge clk);
    check("hr_grant_next_edge", 32'({gnt0, row_req}), 32'b11);
    @(negedge clk);
    host_ready = 1'b0;
    @(negedge clk);
    check("hr_drop_still_done", 32'(done0), 1);
    req0 = 1'b0; host_ready = 1'b1;
    @(negedge clk);

    // reset in WAIT: everything clears, no done, pointer back to requester 0
    req0 = 1'b1; row0 = 6'd11;
    exp_row_q.push_back(6'd11);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_row_req", 32'(row_req), 0);
    check("midrst_row", 32'(row), 0);
    check("midrst_gnt", 32'({gnt0, gnt1}), 0);
    check("midrst_done", 32'({done0, done1}), 0);
    check("midrst_data", 32'({data0, data1}), 0);
    check("midrst_busy", 32'(busy), 0);
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; row0 = 6'd2; row1 = 6'd4;
    exp_row_q.push_back(6'd2);
    exp_done_q.push_back({1'b0, 10'h111});
    @(negedge clk);
    check("postrst_gnt", 32'({gnt1, gnt0}), 32'b01);
    req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("postrst_done0", 32'(done0), 1);
    req0 = 1'b0;
    repeat (4) @(negedge clk);

    check("row_q_drained", 32'(exp_row_q.size()), 0);
    check("done_q_drained", 32'(exp_done_q.size()), 0);
    check("lat4_q_drained", 32'(exp_done_b_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/row_port_arbiter.md
# row_port_arbiter

Arbitrates the single host row-read port (row_req / row / row_info) between two internal requesters of the tetris player: requester 0 is the board snapshot loader, requester 1 is the placement evaluator's lookahead reader. Each requester issues one row read at a time through a req/done handshake; the arbiter serialises them round-robin, drives the host request pulse, waits the host latency and returns the captured row. Rows outside the 20-row board are answered locally as a full floor row without touching the host.

## Interface
- HOST_LAT, 1, cycles from the cycle row_req is high to the cycle row_info is valid; legal 1..4
- NUM_ROWS, 20, board height; valid row indices 0..NUM_ROWS-1
- clk  in  1  clock, all state on rising edge
- reset  in  1  reset, asynchronous, active-high
- host_ready  in  1  host not busy; new grants only while high
- row_req  out  1  one-cycle host read strobe
- row  out  6  row index sent to host, held from grant until next grant
- row_info  in  10  host row data, bit 9 leftmost, bit 0 rightmost
- req0 / req1  in  1  requester read request, held high until its done
- row0 / row1  in  6  requested row index, stable while reqN high
- gnt0 / gnt1  out  1  high from grant edge through the done cycle
- done0 / done1  out  1  one-cycle completion pulse
- data0 / data1  out  10  returned row, valid while doneN high, held until next doneN
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if host_ready=1 and any reqN=1, grant one requester. Both requesting: grant the one not granted last; round-robin pointer resets to favour requester 0. host_ready=0: stay IDLE, no grant.
- Grant, in range (rowN < NUM_ROWS): gntN<=1, row<=rowN, row_req<=1, -> ISSUE.
- Grant, out of range (rowN >= NUM_ROWS): gntN<=1, dataN<=10'h3FF, doneN<=1, no row_req, row unchanged, -> DONE.
- ISSUE: row_req<=0, wait counter<=HOST_LAT-1, -> WAIT.
- WAIT: counter=0: dataN<=row_info, doneN<=1, -> DONE; else decrement.
- DONE: doneN<=0, gntN<=0, -> IDLE. Requests are not evaluated in DONE, so a requester that drops req on seeing done is never re-granted.
- Pointer updates at every grant (in range or out of range) to the granted requester.
- host_ready falling after a grant does not abort; transaction completes.
- reqN dropped before grant: never granted. Dropped after grant: transaction still completes and doneN still pulses.
- Only one of gnt0/gnt1, one of done0/done1 high at any time.
- 6-bit row compare is unsigned; 6'd20..6'd63 are out of range.

## Timing
- Reset values: row_req=0, row=0, gnt0=gnt1=0, done0=done1=0, data0=data1=0, busy=0, state IDLE, pointer favouring requester 0.
- Reset mid-transaction: returns to IDLE immediately, no done pulse, in-flight data discarded.
- Edge E grants (in range): row_req high cycle E..E+1; row_info sampled at edge E+1+HOST_LAT; doneN high cycle E+1+HOST_LAT..E+2+HOST_LAT; IDLE after edge E+2+HOST_LAT; next grant earliest edge E+3+HOST_LAT.
- HOST_LAT=1: grant-to-done 2 edges, grant-to-grant 4 edges.
- Out-of-range: done high cycle E..E+1, IDLE after E+1, next grant earliest edge E+2.
- All outputs registered; no combinational input-to-output path.

## Test plan
- Single read: HOST_LAT=1, req0=1, row0=5, host returns 10'b1100000011 one cycle after row_req -> exactly one row_req pulse with row=5, done0 at edge E+2, data0=10'b1100000011, gnt1/done1 stay 0.
- Contention: req0 and req1 both high from reset, row0=3, row1=7 -> service order 0,1,0,1 with row sequence 3,7,3,7, grants spaced 4 edges apart.
- Out of range: req1=1, row1=20, then row1=63 -> done1 at grant edge, data1=10'h3FF, row_req never asserted.
- host_ready gating: host_ready=0 for 10 cycles with req0=1 -> no row_req, busy=0; host_ready rising -> grant on next edge; host_ready dropped during WAIT -> done0 still pulses with sampled data.
- HOST_LAT=4: req0=1, row0=19 -> row_info sampled at edge E+5, done0 at E+5, data0 equals the host value present at that edge only.
- Reset mid-WAIT: assert reset one cycle after row_req -> all outputs 0 immediately, no done pulse, next request after release is granted to requester 0 first.
